// File: rtl/pwm_multi_pkg.sv
// Purpose: shared register map, bit positions and helpers for the pwm_multi peripheral.
// Ports: none (package).
package pwm_multi_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 4;

  typedef logic [BUS_W-1:0]  bus_word_t;
  typedef logic [ADDR_W-1:0] bus_addr_t;

  // Register word indices
  localparam bus_addr_t REG_CTRL   = 4'd0;
  localparam bus_addr_t REG_PERIOD = 4'd1;
  localparam bus_addr_t REG_PRESC  = 4'd2;
  localparam bus_addr_t REG_STATUS = 4'd3;
  localparam bus_addr_t REG_DUTY0  = 4'd4;

  // CTRL / STATUS bit positions
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_CHEN_LSB = 8;
  localparam int unsigned CTRL_POL_LSB  = 16;
  localparam int unsigned STATUS_WRAP   = 0;

  // Word index of DUTY[ch]
  function automatic bus_addr_t duty_idx(input int unsigned ch);
    return REG_DUTY0 + ADDR_W'(ch);
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// Purpose: one PWM output: programmed/active duty pair, compare and polarity flop.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_count           shared period counter
//   i_wrap            period wrap strobe (loads active duty)
//   i_en/i_chen/i_pol global enable, channel enable, output polarity
//   i_we/i_wdata      DUTY register write
//   o_duty            programmed DUTY for readback
//   o_pwm             registered PWM output
module pwm_channel
  import pwm_multi_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_wrap,
  input  logic             i_en,
  input  logic             i_chen,
  input  logic             i_pol,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_duty,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_duty_act;
  logic             r_pwm;

  // Active duty follows the programmed value while disabled, else only at wrap
  // (non-blocking read of r_duty gives the pre-write value in a wrap cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty     <= '0;
      r_duty_act <= '0;
      r_pwm      <= 1'b0;
    end else begin
      if (i_we) begin
        r_duty <= i_wdata;
      end
      if (!i_en || i_wrap) begin
        r_duty_act <= r_duty;
      end
      r_pwm <= i_pol ^ (i_en & i_chen & (i_count < r_duty_act));
    end
  end

  assign o_duty = r_duty;
  assign o_pwm  = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// Purpose: memory-mapped multi-channel PWM with prescaler, shadowed period/duty
//          and sticky wrap flag.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bSel, bWrite bus select / write strobe (write when both high)
//   bAddr        register word index
//   bWData       write data
//   bRData       combinational read data for bAddr
//   pwmOutput    registered PWM outputs, one per channel
module pwm_multi
  import pwm_multi_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PRESC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bSel,
  input  logic                bWrite,
  input  logic [ADDR_W-1:0]   bAddr,
  input  logic [BUS_W-1:0]    bWData,
  output logic [BUS_W-1:0]    bRData,
  output logic [CHANNELS-1:0] pwmOutput
);

  logic                   r_en;
  logic [CHANNELS-1:0]    r_chen;
  logic [CHANNELS-1:0]    r_pol;
  logic [WIDTH-1:0]       r_period;
  logic [WIDTH-1:0]       r_period_act;
  logic [WIDTH-1:0]       r_count;
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic                   r_wrap_flag;

  logic                   w_wr;
  logic                   w_tick;
  logic                   w_wrap;
  logic [CHANNELS-1:0]    w_duty_we;
  logic [WIDTH-1:0]       w_duty [CHANNELS];
  logic                   w_unused_wdata;

  assign w_wr   = bSel & bWrite;
  assign w_tick = r_en && (r_presc_cnt == r_presc);
  assign w_wrap = w_tick && (r_count == r_period_act);
  // Upper write-data bits are architecturally ignored
  assign w_unused_wdata = ^bWData;

  // Programmed control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en     <= 1'b0;
      r_chen   <= '0;
      r_pol    <= '0;
      r_period <= '1;
      r_presc  <= '0;
    end else if (w_wr) begin
      case (bAddr)
        REG_CTRL: begin
          r_en   <= bWData[CTRL_EN];
          r_chen <= bWData[CTRL_CHEN_LSB +: CHANNELS];
          r_pol  <= bWData[CTRL_POL_LSB +: CHANNELS];
        end
        REG_PERIOD: r_period <= bWData[WIDTH-1:0];
        REG_PRESC:  r_presc  <= bWData[PRESC_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Sticky wrap flag; a wrap in the same cycle beats a W1C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap_flag <= 1'b0;
    end else if (w_wrap) begin
      r_wrap_flag <= 1'b1;
    end else if (w_wr && (bAddr == REG_STATUS) && bWData[STATUS_WRAP]) begin
      r_wrap_flag <= 1'b0;
    end
  end

  // Prescaler, period counter and active period copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt  <= '0;
      r_count      <= '0;
      r_period_act <= '1;
    end else if (!r_en) begin
      r_presc_cnt  <= '0;
      r_count      <= '0;
      r_period_act <= r_period;
    end else begin
      r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_WIDTH'(1);
      if (w_wrap) begin
        r_count      <= '0;
        r_period_act <= r_period;
      end else if (w_tick) begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_duty_we[i] = w_wr && (bAddr == duty_idx(i));

    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_count (r_count),
      .i_wrap  (w_wrap),
      .i_en    (r_en),
      .i_chen  (r_chen[i]),
      .i_pol   (r_pol[i]),
      .i_we    (w_duty_we[i]),
      .i_wdata (bWData[WIDTH-1:0]),
      .o_duty  (w_duty[i]),
      .o_pwm   (pwmOutput[i])
    );
  end

  // Read mux: programmed values only, unmapped indices read 0
  always_comb begin
    bRData = '0;
    case (bAddr)
      REG_CTRL: begin
        bRData[CTRL_EN]                   = r_en;
        bRData[CTRL_CHEN_LSB +: CHANNELS] = r_chen;
        bRData[CTRL_POL_LSB +: CHANNELS]  = r_pol;
      end
      REG_PERIOD: bRData = BUS_W'(r_period);
      REG_PRESC:  bRData = BUS_W'(r_presc);
      REG_STATUS: bRData[STATUS_WRAP] = r_wrap_flag;
      default: begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (bAddr == duty_idx(i)) begin
            bRData = BUS_W'(w_duty[i]);
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Purpose: self-checking bench for pwm_multi (CHANNELS=4, WIDTH=8, PRESC_WIDTH=8).
module tb_pwm_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned NV = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bSel = 1'b0;
  logic          bWrite = 1'b0;
  logic [3:0]    bAddr = '0;
  logic [31:0]   bWData = '0;
  logic [31:0]   bRData;
  logic [CH-1:0] pwmOutput;

  pwm_multi #(.CHANNELS(CH), .WIDTH(8), .PRESC_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bSel      (bSel),
    .bWrite    (bWrite),
    .bAddr     (bAddr),
    .bWData    (bWData),
    .bRData    (bRData),
    .pwmOutput (pwmOutput)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[NV];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_hi[CH];
  int   m_wraps;

  task automatic sb_push(input string name, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] act);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s actual=%h required=%h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bSel = 1'b1; bWrite = 1'b1; bAddr = a; bWData = d;
    @(posedge clk); #1;
    bSel = 1'b0; bWrite = 1'b0;
  endtask

  task automatic do_reset();
    bSel = 1'b0; bWrite = 1'b0; bAddr = '0; bWData = '0;
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      sb_push($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), vecs[i].exp);
      bAddr = vecs[i].addr;
      #1;
      check_pop(bRData);
    end
  endtask

  // Counts high samples per channel and wrap-flag sightings over n clocks,
  // clearing the flag whenever it is seen.
  task automatic measure(input int n);
    m_wraps = 0;
    for (int c = 0; c < int'(CH); c++) m_hi[c] = 0;
    bSel = 1'b0; bWrite = 1'b0; bAddr = 4'd3; bWData = 32'd1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < int'(CH); c++) if (pwmOutput[c]) m_hi[c]++;
      if (bRData[0]) begin
        m_wraps++;
        bSel = 1'b1; bWrite = 1'b1;
      end else begin
        bSel = 1'b0; bWrite = 1'b0;
      end
    end
    bSel = 1'b0; bWrite = 1'b0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int per, pos, duty;

    // Reset values and register readback
    vecs[0]  = '{1'b0, 4'd0,  32'h0,         32'h0};
    vecs[1]  = '{1'b0, 4'd1,  32'h0,         32'h0000_00FF};
    vecs[2]  = '{1'b0, 4'd2,  32'h0,         32'h0};
    vecs[3]  = '{1'b0, 4'd3,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, 4'd4,  32'h0,         32'h0};
    vecs[5]  = '{1'b0, 4'd5,  32'h0,         32'h0};
    vecs[6]  = '{1'b0, 4'd6,  32'h0,         32'h0};
    vecs[7]  = '{1'b0, 4'd7,  32'h0,         32'h0};
    vecs[8]  = '{1'b0, 4'd8,  32'h0,         32'h0};
    vecs[9]  = '{1'b0, 4'd15, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 4'd1,  32'h1234_56AB, 32'h0000_00AB};
    vecs[11] = '{1'b1, 4'd2,  32'hFFFF_FF03, 32'h0000_0003};
    vecs[12] = '{1'b1, 4'd6,  32'hA5A5_A5C4, 32'h0000_00C4};
    vecs[13] = '{1'b1, 4'd0,  32'hFFFF_FFFF, 32'h000F_0F01};
    vecs[14] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0};
    vecs[15] = '{1'b1, 4'd8,  32'hFFFF_FFFF, 32'h0};
    vecs[16] = '{1'b1, 4'd0,  32'h0,         32'h0};

    do_reset();
    sb_push("reset_pwm", 32'h0);
    check_pop(32'(pwmOutput));
    apply_vecs(0, NV - 1);

    // Defaults: PERIOD=255, PRESC=0, DUTY0=64
    do_reset();
    wr(4'd4, 32'd64);
    wr(4'd0, 32'h0000_0101);
    wr(4'd3, 32'd1);
    sb_push("t1_hi0", 32'd128);
    sb_push("t1_hi1", 32'd0);
    sb_push("t1_wraps", 32'd2);
    measure(512);
    check_pop(32'(m_hi[0]));
    check_pop(32'(m_hi[1]));
    check_pop(32'(m_wraps));

    // Prescaler: PRESC=3, PERIOD=9, DUTY1=5 -> 40 clk period, 20 high
    wr(4'd0, 32'h0);
    wr(4'd2, 32'd3);
    wr(4'd1, 32'd9);
    wr(4'd5, 32'd5);
    wr(4'd0, 32'h0000_0201);
    wr(4'd3, 32'd1);
    sb_push("t2_hi1", 32'd40);
    sb_push("t2_hi0", 32'd0);
    sb_push("t2_wraps", 32'd2);
    measure(80);
    check_pop(32'(m_hi[1]));
    check_pop(32'(m_hi[0]));
    check_pop(32'(m_wraps));

    // Edges: DUTY=0 never high, DUTY=PERIOD+1 always high, then inverted
    wr(4'd0, 32'h0);
    wr(4'd2, 32'd0);
    wr(4'd1, 32'd9);
    wr(4'd4, 32'd0);
    wr(4'd5, 32'd10);
    wr(4'd0, 32'h0000_0301);
    wr(4'd3, 32'd1);
    sb_push("t4_duty0_hi", 32'd0);
    sb_push("t4_dutymax_hi", 32'd20);
    sb_push("t4_wraps", 32'd2);
    measure(20);
    check_pop(32'(m_hi[0]));
    check_pop(32'(m_hi[1]));
    check_pop(32'(m_wraps));

    wr(4'd0, 32'h0003_0301);
    wr(4'd3, 32'd1);
    sb_push("t4_pol_duty0_hi", 32'd20);
    sb_push("t4_pol_dutymax_hi", 32'd0);
    sb_push("t4_pol_ch2_hi", 32'd0);
    measure(20);
    check_pop(32'(m_hi[0]));
    check_pop(32'(m_hi[1]));
    check_pop(32'(m_hi[2]));

    // PERIOD=0: count stuck at 0, wrap on every tick
    wr(4'd0, 32'h0);
    wr(4'd1, 32'd0);
    wr(4'd6, 32'd1);
    wr(4'd0, 32'h0000_0401);
    wr(4'd3, 32'd1);
    sb_push("t4_p0_wraps", 32'd10);
    sb_push("t4_p0_hi2", 32'd10);
    measure(10);
    check_pop(32'(m_wraps));
    check_pop(32'(m_hi[2]));

    // Shadowing and STATUS W1C on a cycle-exact timeline.
    // PERIOD=19, DUTY0=10; enable edge is k=0, wraps at k=20,40,60,80,100.
    // DUTY0=3 written mid-period (k=3), DUTY0=7 written in the wrap cycle k=40.
    do_reset();
    wr(4'd1, 32'd19);
    wr(4'd4, 32'd10);
    wr(4'd0, 32'h0000_0101);
    for (int k = 1; k <= 101; k++) begin
      bSel = 1'b0; bWrite = 1'b0;
      if (k == 3) begin
        bSel = 1'b1; bWrite = 1'b1; bAddr = 4'd4; bWData = 32'd3;
      end else if (k == 40) begin
        bSel = 1'b1; bWrite = 1'b1; bAddr = 4'd4; bWData = 32'd7;
      end else if (k == 100 || k == 101) begin
        bSel = 1'b1; bWrite = 1'b1; bAddr = 4'd3; bWData = 32'd1;
      end
      per  = (k - 1) / 20;
      pos  = (k - 1) % 20;
      duty = (per == 0) ? 10 : (per <= 2) ? 3 : 7;
      sb_push($sformatf("shadow_out0_k%0d", k), 32'(pos < duty));
      @(posedge clk); #1;
      bSel = 1'b0; bWrite = 1'b0; bAddr = 4'd3;
      @(negedge clk);
      check_pop(32'(pwmOutput[0]));
      if (k == 100) begin
        sb_push("w1c_same_cycle_as_wrap", 32'd1);
        check_pop(32'(bRData[0]));
      end
      if (k == 101) begin
        sb_push("w1c_no_wrap", 32'd0);
        check_pop(32'(bRData[0]));
      end
    end

    // Async reset mid-period while out0 is high, no clock edge
    #2 rst_n = 1'b0;
    #1;
    sb_push("async_reset_pwm", 32'h0);
    check_pop(32'(pwmOutput));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_vecs(0, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
